// File: rtl/serv_dbg_enc_pkg.sv
// Shared encodings for the debug instruction injector: RV32I opcode fields,
// command op codes, FSM states and small instruction-format assemblers.
package serv_dbg_enc_pkg;

  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_OPIMM  = 7'h13;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_SYSTEM = 7'h73;

  localparam logic [2:0] F3_ADDI  = 3'd0;
  localparam logic [2:0] F3_SW    = 3'd2;
  localparam logic [2:0] F3_CSRRW = 3'd1;
  localparam logic [2:0] F3_CSRRS = 3'd2;

  localparam logic [31:0] INSN_EBREAK = 32'h0010_0073;

  localparam logic [11:0] DEF_DATA_ADDR   = 12'h380;
  localparam logic [11:0] DEF_SCRATCH_CSR = 12'h7B2;
  localparam logic [4:0]  DEF_SCRATCH_REG = 5'd8;

  typedef enum logic [1:0] {
    CMD_RD_GPR = 2'd0,
    CMD_WR_GPR = 2'd1,
    CMD_RD_CSR = 2'd2,
    CMD_WR_CSR = 2'd3
  } cmd_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // I-type layout; CSR instructions reuse it with the CSR address as imm.
  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] opc);
    return {imm, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [6:0] opc);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], opc};
  endfunction

  function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd,
                                        input logic [6:0] opc);
    return {imm, rd, opc};
  endfunction

endpackage

// File: rtl/serv_dbg_insn_enc.sv
// Combinational encoder: (command, step) -> RV32I instruction word and a flag
// marking the final (EBREAK) step of the sequence.
module serv_dbg_insn_enc
  import serv_dbg_enc_pkg::*;
#(
  parameter logic [11:0] DATA_ADDR   = DEF_DATA_ADDR,
  parameter logic [11:0] SCRATCH_CSR = DEF_SCRATCH_CSR,
  parameter logic [4:0]  SCRATCH_REG = DEF_SCRATCH_REG
) (
  input  cmd_op_e     i_op,
  input  logic [2:0]  i_step,
  input  logic [11:0] i_regno,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_insn,
  output logic        o_last
);

  logic [19:0] w_hi;
  logic [11:0] w_lo;
  logic [4:0]  w_rd;

  // Rounding the upper part compensates for ADDI sign-extending the low 12 bits.
  assign w_hi = i_wdata[31:12] + {19'd0, i_wdata[11]};
  assign w_lo = i_wdata[11:0];
  assign w_rd = i_regno[4:0];

  always_comb begin
    o_insn = INSN_EBREAK;
    o_last = 1'b0;
    unique case (i_op)
      CMD_RD_GPR: begin
        case (i_step)
          3'd0:    o_insn = enc_s(DATA_ADDR, w_rd, 5'd0, F3_SW, OPC_STORE);
          default: o_last = 1'b1;
        endcase
      end
      CMD_WR_GPR: begin
        case (i_step)
          3'd0:    o_insn = enc_u(w_hi, w_rd, OPC_LUI);
          3'd1:    o_insn = enc_i(w_lo, w_rd, F3_ADDI, w_rd, OPC_OPIMM);
          default: o_last = 1'b1;
        endcase
      end
      CMD_RD_CSR: begin
        case (i_step)
          3'd0:    o_insn = enc_i(SCRATCH_CSR, SCRATCH_REG, F3_CSRRW, 5'd0, OPC_SYSTEM);
          3'd1:    o_insn = enc_i(i_regno, 5'd0, F3_CSRRS, SCRATCH_REG, OPC_SYSTEM);
          3'd2:    o_insn = enc_s(DATA_ADDR, SCRATCH_REG, 5'd0, F3_SW, OPC_STORE);
          3'd3:    o_insn = enc_i(SCRATCH_CSR, 5'd0, F3_CSRRS, SCRATCH_REG, OPC_SYSTEM);
          default: o_last = 1'b1;
        endcase
      end
      CMD_WR_CSR: begin
        case (i_step)
          3'd0:    o_insn = enc_i(SCRATCH_CSR, SCRATCH_REG, F3_CSRRW, 5'd0, OPC_SYSTEM);
          3'd1:    o_insn = enc_u(w_hi, SCRATCH_REG, OPC_LUI);
          3'd2:    o_insn = enc_i(w_lo, SCRATCH_REG, F3_ADDI, SCRATCH_REG, OPC_OPIMM);
          3'd3:    o_insn = enc_i(i_regno, SCRATCH_REG, F3_CSRRW, 5'd0, OPC_SYSTEM);
          3'd4:    o_insn = enc_i(SCRATCH_CSR, 5'd0, F3_CSRRS, SCRATCH_REG, OPC_SYSTEM);
          default: o_last = 1'b1;
        endcase
      end
      default: o_last = 1'b1;
    endcase
  end

endmodule

// File: rtl/serv_dbg_insn_inject.sv
// Debug instruction injector: latches a register-access command and serves its
// instruction sequence as one-cycle-latency ibus read responses, ending in EBREAK.
module serv_dbg_insn_inject
  import serv_dbg_enc_pkg::*;
#(
  parameter logic [11:0] DATA_ADDR   = DEF_DATA_ADDR,
  parameter logic [11:0] SCRATCH_CSR = DEF_SCRATCH_CSR,
  parameter logic [4:0]  SCRATCH_REG = DEF_SCRATCH_REG
) (
  input  logic        clk,
  input  logic        i_rst_n,
  input  logic        i_cmd_valid,
  output logic        o_cmd_ready,
  input  logic [1:0]  i_cmd_op,
  input  logic [11:0] i_cmd_regno,
  input  logic [31:0] i_cmd_wdata,
  input  logic        i_abort,
  output logic        o_busy,
  output logic        o_done,
  input  logic        i_ibus_cyc,
  output logic [31:0] o_ibus_rdt,
  output logic        o_ibus_ack
);

  state_e      r_state, w_state_nxt;
  logic [2:0]  r_step, w_step_nxt;
  cmd_op_e     r_op;
  logic [11:0] r_regno;
  logic [31:0] r_wdata;
  logic        r_ack, r_done;
  logic [31:0] r_rdt;
  logic        w_accept, w_launch, w_last;
  logic [31:0] w_insn;

  serv_dbg_insn_enc #(
    .DATA_ADDR   (DATA_ADDR),
    .SCRATCH_CSR (SCRATCH_CSR),
    .SCRATCH_REG (SCRATCH_REG)
  ) u_enc (
    .i_op    (r_op),
    .i_step  (r_step),
    .i_regno (r_regno),
    .i_wdata (r_wdata),
    .o_insn  (w_insn),
    .o_last  (w_last)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_step_nxt  = r_step;
    w_accept    = 1'b0;
    w_launch    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_cmd_valid) begin
          w_accept    = 1'b1;
          w_step_nxt  = '0;
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        // Abort wins over a new fetch; an ack already registered still completes.
        if (i_abort) begin
          w_state_nxt = ST_IDLE;
        end else if (i_ibus_cyc && !r_ack) begin
          w_launch   = 1'b1;
          w_step_nxt = r_step + 3'd1;
          if (w_last) w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_step  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_step  <= w_step_nxt;
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ack   <= 1'b0;
      r_done  <= 1'b0;
      r_rdt   <= '0;
      r_op    <= CMD_RD_GPR;
      r_regno <= '0;
      r_wdata <= '0;
    end else begin
      r_ack  <= w_launch;
      r_done <= w_launch && w_last;
      r_rdt  <= w_launch ? w_insn : '0;
      if (w_accept) begin
        r_op    <= cmd_op_e'(i_cmd_op);
        r_regno <= i_cmd_regno;
        r_wdata <= i_cmd_wdata;
      end
    end
  end

  assign o_cmd_ready = (r_state == ST_IDLE);
  assign o_busy      = (r_state == ST_RUN);
  assign o_done      = r_done;
  assign o_ibus_ack  = r_ack;
  assign o_ibus_rdt  = r_rdt;

endmodule

// File: tb/tb_serv_dbg_insn_inject.sv
// Self-checking bench: queue-based reference model compared every cycle, plus
// literal instruction words for the directed command sequences.
module tb_serv_dbg_insn_inject;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_cmd_valid = 1'b0;
  logic        o_cmd_ready;
  logic [1:0]  i_cmd_op = '0;
  logic [11:0] i_cmd_regno = '0;
  logic [31:0] i_cmd_wdata = '0;
  logic        i_abort = 1'b0;
  logic        o_busy, o_done;
  logic        i_ibus_cyc = 1'b0;
  logic [31:0] o_ibus_rdt;
  logic        o_ibus_ack;

  serv_dbg_insn_inject dut (
    .clk         (clk),
    .i_rst_n     (rst_n),
    .i_cmd_valid (i_cmd_valid),
    .o_cmd_ready (o_cmd_ready),
    .i_cmd_op    (i_cmd_op),
    .i_cmd_regno (i_cmd_regno),
    .i_cmd_wdata (i_cmd_wdata),
    .i_abort     (i_abort),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .i_ibus_cyc  (i_ibus_cyc),
    .o_ibus_rdt  (o_ibus_rdt),
    .o_ibus_ack  (o_ibus_ack)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] f_itype(input logic [31:0] imm, input logic [31:0] rs1,
                                          input logic [31:0] f3, input logic [31:0] rd,
                                          input logic [31:0] opc);
    return (imm << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | opc;
  endfunction

  function automatic logic [31:0] f_sw(input logic [31:0] rs2);
    logic [31:0] a;
    a = 32'h380;
    return ((a >> 5) << 25) | (rs2 << 20) | (32'd2 << 12) | ((a & 32'd31) << 7) | 32'h23;
  endfunction

  function automatic logic [31:0] f_lui(input logic [31:0] rd, input logic [31:0] hi);
    return (hi << 12) | (rd << 7) | 32'h37;
  endfunction

  logic [31:0] m_q[$];
  bit          m_busy, m_ack, m_done, m_prev_ack;
  logic [31:0] m_rdt;

  task automatic m_build(input logic [1:0] op, input logic [11:0] rg, input logic [31:0] wd);
    logic [31:0] hi, lo, rd, csr, s0, scr;
    hi  = (wd + 32'h800) >> 12;
    lo  = wd & 32'hFFF;
    rd  = {27'd0, rg[4:0]};
    csr = {20'd0, rg};
    s0  = 32'd8;
    scr = 32'h7B2;
    m_q.delete();
    case (op)
      2'd0: m_q.push_back(f_sw(rd));
      2'd1: begin
        m_q.push_back(f_lui(rd, hi));
        m_q.push_back(f_itype(lo, rd, 0, rd, 32'h13));
      end
      2'd2: begin
        m_q.push_back(f_itype(scr, s0, 1, 0, 32'h73));
        m_q.push_back(f_itype(csr, 0, 2, s0, 32'h73));
        m_q.push_back(f_sw(s0));
        m_q.push_back(f_itype(scr, 0, 2, s0, 32'h73));
      end
      default: begin
        m_q.push_back(f_itype(scr, s0, 1, 0, 32'h73));
        m_q.push_back(f_lui(s0, hi));
        m_q.push_back(f_itype(lo, s0, 0, s0, 32'h13));
        m_q.push_back(f_itype(csr, s0, 1, 0, 32'h73));
        m_q.push_back(f_itype(scr, 0, 2, s0, 32'h73));
      end
    endcase
    m_q.push_back(32'h0010_0073);
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_ack = 0; m_done = 0; m_rdt = '0;
      m_q.delete();
    end else begin
      m_prev_ack = m_ack;
      m_ack = 0; m_done = 0; m_rdt = '0;
      if (!m_busy) begin
        if (i_cmd_valid) begin
          m_build(i_cmd_op, i_cmd_regno, i_cmd_wdata);
          m_busy = 1;
        end
      end else if (i_abort) begin
        m_busy = 0;
        m_q.delete();
      end else if (i_ibus_cyc && !m_prev_ack) begin
        m_rdt = m_q.pop_front();
        m_ack = 1;
        if (m_q.size() == 0) begin
          m_done = 1;
          m_busy = 0;
        end
      end
    end
  end

  // ---------------- compare process ----------------
  logic [31:0] cap[$];
  bit          done_seen;
  int          done_at;
  logic        last_ack = 1'b0;

  always @(negedge clk) begin
    chk("ack", {31'd0, o_ibus_ack}, {31'd0, m_ack});
    chk("done", {31'd0, o_done}, {31'd0, m_done});
    chk("busy", {31'd0, o_busy}, {31'd0, m_busy});
    chk("cmd_ready", {31'd0, o_cmd_ready}, {31'd0, !m_busy});
    if (m_ack) chk("rdt", o_ibus_rdt, m_rdt);
    chk("ack_b2b", {31'd0, o_ibus_ack & last_ack}, 32'd0);
    if (o_ibus_ack) cap.push_back(o_ibus_rdt);
    if (o_done) begin
      done_seen = 1;
      done_at = cap.size();
    end
    last_ack = o_ibus_ack;
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_cap();
    cap.delete();
    done_seen = 0;
    done_at = -1;
  endtask

  task automatic do_cmd(input logic [1:0] op, input logic [11:0] rg, input logic [31:0] wd);
    i_cmd_valid = 1'b1;
    i_cmd_op = op;
    i_cmd_regno = rg;
    i_cmd_wdata = wd;
    tick();
    i_cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    for (int n = 0; n < budget && !done_seen; n++) tick();
    chk({name, "_done_seen"}, {31'd0, done_seen}, 32'd1);
  endtask

  task automatic check_words(input string name, input logic [31:0] exp[6], input int n);
    chk({name, "_count"}, cap.size(), n);
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_w%0d", name, i), (i < cap.size()) ? cap[i] : 32'hDEAD_BEEF, exp[i]);
  endtask

  logic [31:0] exp_w[6];

  initial begin
    clear_cap();
    // Reset state while held in reset
    #2;
    chk("rst_busy", {31'd0, o_busy}, 32'd0);
    chk("rst_done", {31'd0, o_done}, 32'd0);
    chk("rst_ack", {31'd0, o_ibus_ack}, 32'd0);
    chk("rst_rdt", o_ibus_rdt, 32'd0);
    chk("rst_ready", {31'd0, o_cmd_ready}, 32'd1);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // Write GPR x5 = 0x12345FFF, fetch held high throughout
    clear_cap();
    do_cmd(2'd1, 12'd5, 32'h1234_5FFF);
    i_ibus_cyc = 1'b1;
    wait_done("wgpr", 30);
    i_ibus_cyc = 1'b0;
    exp_w = '{32'h1234_62B7, 32'hFFF2_8293, 32'h0010_0073, 0, 0, 0};
    check_words("wgpr", exp_w, 3);
    chk("wgpr_done_at", done_at, 32'd3);

    // Read GPR x10
    clear_cap();
    do_cmd(2'd0, 12'd10, 32'h0);
    i_ibus_cyc = 1'b1;
    wait_done("rgpr", 30);
    i_ibus_cyc = 1'b0;
    exp_w = '{32'h38A0_2023, 32'h0010_0073, 0, 0, 0, 0};
    check_words("rgpr", exp_w, 2);
    chk("rgpr_done_at", done_at, 32'd2);

    // Read CSR 0x341, with a second command offered while busy
    clear_cap();
    do_cmd(2'd2, 12'h341, 32'h0);
    i_ibus_cyc = 1'b1;
    i_cmd_valid = 1'b1;
    i_cmd_op = 2'd1;
    i_cmd_regno = 12'd3;
    repeat (2) tick();
    i_cmd_valid = 1'b0;
    wait_done("rcsr", 40);
    i_ibus_cyc = 1'b0;
    exp_w = '{32'h7B24_1073, 32'h3410_2473, 32'h3880_2023, 32'h7B20_2473, 32'h0010_0073, 0};
    check_words("rcsr", exp_w, 5);
    tick();
    chk("rcsr_idle_after", {31'd0, o_busy}, 32'd0);

    // Fetch requests while idle are never acknowledged
    clear_cap();
    i_ibus_cyc = 1'b1;
    repeat (8) tick();
    i_ibus_cyc = 1'b0;
    chk("idle_no_ack", cap.size(), 32'd0);

    // Abort write CSR after its second ack
    clear_cap();
    do_cmd(2'd3, 12'h300, 32'hCAFE_0123);
    i_ibus_cyc = 1'b1;
    for (int n = 0; n < 20 && cap.size() < 2; n++) tick();
    chk("abort_two_acks", cap.size(), 32'd2);
    i_ibus_cyc = 1'b0;
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    chk("abort_busy", {31'd0, o_busy}, 32'd0);
    chk("abort_ready", {31'd0, o_cmd_ready}, 32'd1);
    chk("abort_no_done", {31'd0, done_seen}, 32'd0);
    exp_w = '{32'h7B24_1073, 32'hCAFE_0437, 0, 0, 0, 0};
    check_words("abort_wcsr", exp_w, 2);
    clear_cap();
    do_cmd(2'd0, 12'd10, 32'h0);
    i_ibus_cyc = 1'b1;
    wait_done("after_abort", 30);
    i_ibus_cyc = 1'b0;
    exp_w = '{32'h38A0_2023, 32'h0010_0073, 0, 0, 0, 0};
    check_words("after_abort", exp_w, 2);

    // Asynchronous reset mid-sequence
    clear_cap();
    do_cmd(2'd3, 12'h7C0, 32'h0000_0ABC);
    i_ibus_cyc = 1'b1;
    repeat (3) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", {31'd0, o_busy}, 32'd0);
    chk("arst_ack", {31'd0, o_ibus_ack}, 32'd0);
    chk("arst_done", {31'd0, o_done}, 32'd0);
    chk("arst_rdt", o_ibus_rdt, 32'd0);
    chk("arst_ready", {31'd0, o_cmd_ready}, 32'd1);
    i_ibus_cyc = 1'b0;
    repeat (2) tick();
    #1;
    rst_n = 1'b1;
    tick();
    chk("arst_idle", {31'd0, o_cmd_ready}, 32'd1);
    clear_cap();
    do_cmd(2'd0, 12'd10, 32'h0);
    i_ibus_cyc = 1'b1;
    wait_done("after_rst", 30);
    i_ibus_cyc = 1'b0;
    check_words("after_rst", exp_w, 2);

    // Randomized traffic against the model
    for (int n = 0; n < 500; n++) begin
      i_cmd_valid = ($urandom_range(0, 3) == 0);
      i_cmd_op    = 2'($urandom_range(0, 3));
      i_cmd_regno = 12'($urandom);
      i_cmd_wdata = $urandom;
      i_ibus_cyc  = ($urandom_range(0, 2) != 0);
      i_abort     = ($urandom_range(0, 39) == 0);
      tick();
    end
    i_cmd_valid = 1'b0;
    i_ibus_cyc  = 1'b0;
    i_abort     = 1'b0;
    repeat (4) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serv_dbg_insn_inject.md
Name: serv_dbg_insn_inject

Overview:
- Debug-side instruction encoder/injector: turns abstract register-access commands into RV32I instruction sequences and serves them as instruction-bus read responses to the SERV core in debug mode.
- Each sequence ends in EBREAK, so the core re-enters the debug park loop.
- It feeds the core's fetch/decode path: instruction word plus ack, consumed on the decoder's enable.
- GPR/CSR read results leave the core as a SW to DATA_ADDR, captured by the existing debug data-bus tap.

Parameters:
- DATA_ADDR, 12'h380, signed 12-bit offset from x0 used for SW result stores.
- SCRATCH_CSR, 12'h7B2, CSR used to save s0 (dscratch0).
- SCRATCH_REG, 5'd8, GPR clobbered and restored during CSR access (s0).

Ports:
- clk  input  1  clock.
- i_rst_n  input  1  reset, asynchronous, active-low.
- i_cmd_valid  input  1  command request.
- o_cmd_ready  output  1  high in IDLE only.
- i_cmd_op  input  2  0=read GPR, 1=write GPR, 2=read CSR, 3=write CSR.
- i_cmd_regno  input  12  GPR index in [4:0], or CSR address.
- i_cmd_wdata  input  32  write value.
- i_abort  input  1  drop the current sequence.
- o_busy  output  1  sequence in progress.
- o_done  output  1  one-cycle pulse with the EBREAK ack.
- i_ibus_cyc  input  1  core fetch request.
- o_ibus_rdt  output  32  instruction word.
- o_ibus_ack  output  1  fetch acknowledge, one-cycle pulse.

Behaviour:
- Reset: state IDLE, step=0, o_busy=0, o_done=0, o_ibus_ack=0, o_ibus_rdt=0, latched command cleared.
- States: IDLE, RUN.
- IDLE: o_cmd_ready=1. On i_cmd_valid, latch op/regno/wdata, step=0, go to RUN. i_ibus_cyc in IDLE is never acked.
- RUN: when i_ibus_cyc=1 and o_ibus_ack=0, the next cycle drives o_ibus_ack=1 and o_ibus_rdt=seq[op][step], then step increments. Latency is one cycle per fetch. The cycle after an ack is never acked, even if cyc is still high.
- Fetch address is ignored; words are served strictly in step order.
- Sequences (hi=(wdata+32'h800)>>12, lo=wdata[11:0], rd=regno[4:0]):
  - read GPR: SW rd,DATA_ADDR(x0); EBREAK.
  - write GPR: LUI rd,hi; ADDI rd,rd,lo; EBREAK.
  - read CSR: CSRRW x0,SCRATCH_CSR,s0; CSRRS s0,csr,x0; SW s0,DATA_ADDR(x0); CSRRS s0,SCRATCH_CSR,x0; EBREAK.
  - write CSR: CSRRW x0,SCRATCH_CSR,s0; LUI s0,hi; ADDI s0,s0,lo; CSRRW x0,csr,s0; CSRRS s0,SCRATCH_CSR,x0; EBREAK.
- The step counter is 3 bits; the maximum sequence length is 6.
- On the EBREAK ack: o_done=1 in the same cycle, state returns to IDLE.
- Write GPR with rd=0 still emits the sequence; the core discards the writes.
- i_abort in RUN returns to IDLE next cycle with no o_done. If an ack is already launched, it completes.
- i_cmd_valid while busy is ignored, since o_cmd_ready=0.
- o_busy = (state==RUN).
- Reset asserted mid-sequence forces IDLE asynchronously and zeroes the outputs.

Decomposition:
- Shared package serv_dbg_enc_pkg:
  - opcodes: LUI 7'h37, OPIMM 7'h13, STORE 7'h23, SYSTEM 7'h73.
  - funct3 values: ADDI 0, SW 2, CSRRW 1, CSRRS 2.
  - EBREAK word 32'h00100073.
  - command op encodings.
- One combinational sub-module, serv_dbg_insn_enc: (op, step, regno, wdata) -> {insn[31:0], last}. The FSM, counter and bus handshake stay in the top module.

Test Plan:
- Write GPR, op=1, regno=5, wdata=32'h12345FFF, core fetching back-to-back -> acks carry 32'h123462B7, 32'hFFF28293, 32'h00100073; o_done pulses with the 3rd ack.
- Read GPR, op=0, regno=10 -> 32'h38A02023, 32'h00100073.
- Read CSR, op=2, regno=12'h341 -> 32'h7B241073, 32'h34102473, 32'h38802023, 32'h7B202473, 32'h00100073.
- Handshake: i_ibus_cyc held high continuously -> ack never on two consecutive cycles. cyc in IDLE -> no ack ever. New cmd while busy -> not accepted.
- i_abort after 2nd ack of write CSR -> IDLE next cycle, no o_done, o_cmd_ready=1. Next command restarts at step 0.
- i_rst_n pulsed low mid-RUN, asynchronous to clk -> outputs 0 immediately, IDLE after release.
